// File: rtl/maxnet_controller.sv
// ---------------------------------------------------------------------------
// maxnet_controller
//
// Control FSM for the iterative winner-take-all (MAXNET) datapath. On a start
// request it loads X1..X4, then repeats processing-unit / activation-register
// cycles until the datapath reports that exactly one activation remains
// (complete, sampled only in CHECK). It then enables the final result register
// and pulses done for one cycle.
//
// Optional feature (macro MAXNET_TIMEOUT_EN):
//   defined   - a run that has completed MAX_ITER iterations without complete
//               goes from CHECK straight to DONE (no result write) and raises
//               timeout alongside done.
//   undefined - no iteration limit; timeout is tied low.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   run request, sampled only in IDLE
//   complete    in   datapath: exactly one activation remains nonzero
//   sel         out  1 = processing units read X register, 0 = activation reg
//   en0         out  X register load enable
//   en1         out  processing-unit register enable
//   en2         out  activation register enable
//   en3         out  final result register enable
//   busy        out  high in every state except IDLE and DONE
//   done        out  one-cycle completion pulse
//   timeout     out  qualifies done: run ended by the iteration limit
//   iter_count  out  iterations completed in the current/last run
// ---------------------------------------------------------------------------
module maxnet_controller #(
  parameter int ITER_W   = 6,
  parameter int MAX_ITER = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              complete,
  output logic              sel,
  output logic              en0,
  output logic              en1,
  output logic              en2,
  output logic              en3,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_UPDATE,
    S_CHECK,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ITER_W-1:0] ITER_SAT = {ITER_W{1'b1}};

  state_t            state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              first_q, first_d;

`ifdef MAXNET_TIMEOUT_EN
  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);
  // Remembers that DONE was entered through the iteration limit.
  logic              to_q, to_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
      first_q <= 1'b1;
`ifdef MAXNET_TIMEOUT_EN
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      first_q <= first_d;
`ifdef MAXNET_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    first_d = first_q;
`ifdef MAXNET_TIMEOUT_EN
    to_d    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          iter_d  = '0;
          first_d = 1'b1;
        end
      end
      S_LOAD:    state_d = S_COMPUTE;
      S_COMPUTE: state_d = S_UPDATE;
      S_UPDATE: begin
        // Counter saturates so a never-converging run cannot wrap it.
        if (iter_q != ITER_SAT) iter_d = iter_q + 1'b1;
        first_d = 1'b0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (complete) begin
          state_d = S_WRITE;
`ifdef MAXNET_TIMEOUT_EN
        end else if (iter_q == ITER_LIMIT) begin
          state_d = S_DONE;
          to_d    = 1'b1;
`endif
        end else begin
          state_d = S_COMPUTE;
        end
      end
      S_WRITE:   state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Moore outputs: the first COMPUTE of a run reads X, later ones read the
  // activation register.
  assign sel        = (state_q == S_LOAD) || ((state_q == S_COMPUTE) && first_q);
  assign en0        = (state_q == S_LOAD);
  assign en1        = (state_q == S_COMPUTE);
  assign en2        = (state_q == S_UPDATE);
  assign en3        = (state_q == S_WRITE);
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign iter_count = iter_q;

`ifdef MAXNET_TIMEOUT_EN
  assign timeout = (state_q == S_DONE) && to_q;
`else
  assign timeout = 1'b0;
`endif

endmodule
